// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_DM   = 2'd2
  } rsp_owner_e;

  // Width of a counter that must hold 0..max inclusive.
  function automatic int unsigned starve_cnt_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between instruction fetch and data load/store.
// Data side wins ties unless fetch has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;
  rsp_owner_e       rsp_q, rsp_d;
  logic             if_gnt, dm_gnt;

  // Grant, memory drive and next-state decode.
  always_comb begin
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    starve_d    = '0;
    rsp_d       = RSP_NONE;

    if (!i_rst) begin
      if (i_if_req && (!i_dm_req || starve_q == CNT_MAX)) begin
        if_gnt = 1'b1;
      end else if (i_dm_req) begin
        dm_gnt = 1'b1;
      end
    end

    if (if_gnt) begin
      o_mem_addr = i_if_addr;
      rsp_d      = RSP_IF;
    end else if (dm_gnt) begin
      o_mem_we    = i_dm_we;
      o_mem_addr  = i_dm_addr;
      o_mem_wdata = i_dm_wdata;
      rsp_d       = i_dm_we ? RSP_NONE : RSP_DM;
    end

    if (i_if_req && !if_gnt) begin
      starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_q    <= RSP_NONE;
      starve_q <= '0;
    end else begin
      rsp_q    <= rsp_d;
      starve_q <= starve_d;
    end
  end

  // Reset also masks a response already in flight.
  always_comb begin
    o_if_gnt    = if_gnt;
    o_dm_gnt    = dm_gnt;
    o_if_rvalid = !i_rst && (rsp_q == RSP_IF);
    o_dm_rvalid = !i_rst && (rsp_q == RSP_DM);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_dm_rdata  = o_dm_rvalid ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple write-first SRAM model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .i_dm_req   (dm_req),
    .i_dm_we    (dm_we),
    .i_dm_addr  (dm_addr),
    .i_dm_wdata (dm_wdata),
    .o_dm_gnt   (dm_gnt),
    .o_dm_rvalid(dm_rvalid),
    .o_dm_rdata (dm_rdata),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Synchronous SRAM, one-cycle read latency, write-first.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      mem_rdata          <= mem_wdata;
    end else begin
      mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic [AW-1:0] ia,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
    if_req = ir; if_addr = ia;
    dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    return ref_mem[idx];
  endfunction

  task automatic chk_grant(input string tag, input logic exp_if, input logic exp_dm,
                           input logic exp_we, input logic [AW-1:0] exp_addr);
    chk({tag, ".if_gnt"}, DW'(if_gnt), DW'(exp_if));
    chk({tag, ".dm_gnt"}, DW'(dm_gnt), DW'(exp_dm));
    chk({tag, ".mem_we"}, DW'(mem_we), DW'(exp_we));
    chk({tag, ".mem_addr"}, mem_addr, exp_addr);
  endtask

  task automatic chk_rsp(input string tag, input logic exp_if, input logic exp_dm,
                         input logic [DW-1:0] exp_data);
    chk({tag, ".if_rvalid"}, DW'(if_rvalid), DW'(exp_if));
    chk({tag, ".dm_rvalid"}, DW'(dm_rvalid), DW'(exp_dm));
    chk({tag, ".if_rdata"}, if_rdata, exp_if ? exp_data : '0);
    chk({tag, ".dm_rdata"}, dm_rdata, exp_dm ? exp_data : '0);
  endtask

  initial begin
    logic          exp_f;
    logic [AW-1:0] a;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE_0000 + DW'(i);
      ref_mem[i] = 32'hC0DE_0000 + DW'(i);
    end
    mem_rdata = '0;

    // Reset with both requesters active: nothing granted, all outputs quiet.
    rst = 1'b1;
    set_in(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    tick; tick;
    #1;
    chk_grant("rst", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk_rsp("rst", 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    rst = 1'b0;
    tick;
    chk_rsp("post_rst", 1'b0, 1'b0, 32'h0);

    // Fetch only.
    set_in(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 chk_grant("fetch", 1'b1, 1'b0, 1'b0, 32'h10);
    tick;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_rsp("fetch", 1'b1, 1'b0, 32'hC0DE_0004);

    // Store then load same address.
    set_in(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    #1 chk_grant("store", 1'b0, 1'b1, 1'b1, 32'h40);
    chk("store.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    ref_mem[16] = 32'hDEAD_BEEF;
    tick;
    chk_rsp("store", 1'b0, 1'b0, 32'h0);
    set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    #1 chk_grant("load", 1'b0, 1'b1, 1'b0, 32'h40);
    tick;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_rsp("load", 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick;
    chk_rsp("idle", 1'b0, 1'b0, 32'h0);

    // Both held 10 cycles: data 0-3, fetch 4, data 5-8, fetch 9.
    set_in(1'b1, 32'h80, 1'b1, 1'b0, 32'h84, 32'h0);
    for (int c = 0; c < 10; c++) begin
      exp_f = (c == 4) || (c == 9);
      #1 chk_grant($sformatf("starve%0d", c), exp_f, !exp_f, 1'b0, exp_f ? 32'h80 : 32'h84);
      tick;
      chk_rsp($sformatf("starve%0d", c), exp_f, !exp_f, exp_f ? ref_rd(32'h80) : ref_rd(32'h84));
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;

    // Build fetch starvation to 4, then reset right after a load grant.
    set_in(1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 4; c++) begin
      #1 chk_grant($sformatf("pre_rst%0d", c), 1'b0, 1'b1, 1'b0, 32'h40);
      tick;
      if (c < 3) chk_rsp($sformatf("pre_rst%0d", c), 1'b0, 1'b1, 32'hDEAD_BEEF);
    end
    rst = 1'b1;
    #1;
    chk_grant("mid_rst", 1'b0, 1'b0, 1'b0, 32'h0);
    chk_rsp("mid_rst", 1'b0, 1'b0, 32'h0);
    tick;
    rst = 1'b0;
    // A surviving counter of 4 would hand this cycle to fetch.
    #1 chk_grant("after_rst", 1'b0, 1'b1, 1'b0, 32'h40);
    chk_rsp("after_rst0", 1'b0, 1'b0, 32'h0);
    tick;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_rsp("after_rst1", 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick;

    // Alternating fetch / load with random word addresses.
    for (int i = 0; i < 100; i++) begin
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if (i % 2 == 0) set_in(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
      else            set_in(1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0);
      #1 chk_grant($sformatf("alt%0d", i), (i % 2 == 0), (i % 2 != 0), 1'b0, a);
      tick;
      chk_rsp($sformatf("alt%0d", i), (i % 2 == 0), (i % 2 != 0), ref_rd(a));
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick;
    chk_rsp("final_idle", 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
